sdram_req_sched: RTL
====================

# sdram_req_sched

Upstream request scheduler for the SDRAM controller. It watches the user write FIFO and user read FIFO fill levels and issues one full-burst write or read request at a time. It also holds the burst length, maintains wrapping SDRAM write and read word pointers plus the SDRAM occupancy count, and drives the burst address. Together with the controller, this makes the SDRAM behave as one large FIFO between the write FIFO and the read FIFO.

## Interface
Parameters:
- BURST_LEN, 256: words per burst; power of two, 2..512; drives sdwr_byte/sdrd_byte.
- ADDR_W, 22: SDRAM word-address width (bank+row+col); capacity DEPTH = 2^ADDR_W words.
- RDF_DEPTH, 512: read FIFO depth in words; must be ≥ BURST_LEN.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  reset: asynchronous, active-low; clock clk.
- sdram_init_done  in  1  controller initialisation complete.
- flush  in  1  synchronous clear of pointers and level.
- wrf_usedw  in  10  write FIFO used words.
- rdf_usedw  in  10  read FIFO used words.
- sdram_wr_req  out  1  write burst request.
- sdram_rd_req  out  1  read burst request.
- sdram_wr_ack  in  1  controller write acknowledge; high for the whole data phase.
- sdram_rd_ack  in  1  controller read acknowledge; high for the whole data phase.
- sdwr_byte  out  10  write burst length, constant BURST_LEN.
- sdrd_byte  out  10  read burst length, constant BURST_LEN.
- sys_addr  out  ADDR_W  start word address of the current burst.
- sdram_level  out  ADDR_W+1  words held in SDRAM.
- sdram_full  out  1  sdram_level > DEPTH − BURST_LEN.
- sdram_empty  out  1  sdram_level < BURST_LEN.

## Operation
- Eligibility:
  - wr_ok = init_done & (wrf_usedw ≥ BURST_LEN) & !sdram_full.
  - rd_ok = init_done & !sdram_empty & (rdf_usedw ≤ RDF_DEPTH − BURST_LEN).
- Arbitration in S_IDLE:
  - Only one eligible: take it.
  - Both eligible: take the opposite of the last_wr flag (alternate).
  - last_wr resets to 0, so the first tie goes to write.
- FSM states: S_IDLE, S_WREQ, S_WBURST, S_RREQ, S_RBURST, S_GAP.
  - S_IDLE → S_WREQ / S_RREQ per arbitration. Stay in S_IDLE if neither is eligible or flush is high.
  - S_WREQ: hold sdram_wr_req=1 until sdram_wr_ack=1, then drop the request and go to S_WBURST.
  - S_WBURST: on the falling edge of wr_ack, wr_ptr += BURST_LEN, level += BURST_LEN, last_wr=1, then go to S_GAP.
  - S_RREQ / S_RBURST: symmetric using rd_ack. On completion, rd_ptr += BURST_LEN, level −= BURST_LEN, last_wr=0.
  - S_GAP: one cycle, then S_IDLE. This lets the controller return to its idle state before the next request.
- Pointer and level arithmetic:
  - Pointers are ADDR_W bits and wrap modulo 2^ADDR_W with no special case.
  - Bursts never straddle the wrap.
  - Level is never updated by a write and a read in the same cycle, because bursts are serialised.
- sys_addr:
  - wr_ptr in S_WREQ/S_WBURST; rd_ptr in S_RREQ/S_RBURST.
  - Otherwise wr_ptr.
  - Stable for the entire request and burst.
- flush:
  - Acted on only in S_IDLE/S_GAP: clears wr_ptr, rd_ptr, level and last_wr next cycle.
  - Asserted during a request or burst: latched, applied after the burst completes.
  - The completed burst's update is discarded.
- Refresh may delay ack arbitrarily. The request stays asserted with no timeout.

## Timing
- Reset values: sdram_wr_req=0, sdram_rd_req=0, sys_addr=0, sdram_level=0, sdram_empty=1, sdram_full=0. State = S_IDLE.
- sdwr_byte and sdrd_byte = BURST_LEN at all times.
- All outputs are registered except sdwr_byte, sdrd_byte, full and empty (decoded from the level register).
- Request latency: eligibility is true in S_IDLE at edge N, and the request is high from N+1.
- Request drop: the request goes low on the edge after ack is first sampled high.
- Completion: pointer and level update on the edge after ack is sampled low in the BURST state. Full/empty reflect the update the same cycle.
- Minimum spacing from burst end to the next request: 2 cycles (S_GAP, S_IDLE).
- Reset mid-burst: everything returns to reset values immediately. The controller is reset by the same rst_n.

## Structure
- Shared package sdram_sched_pkg:
  - State encoding constants S_IDLE..S_GAP.
  - Defaults for BURST_LEN, ADDR_W, RDF_DEPTH.
  - The 10-bit usedw width constant.
- Sub-module sdram_burst_ptr:
  - ADDR_W wrapping pointer with inc and clr inputs.
  - Instantiated twice, for wr_ptr and rd_ptr.
- Level counter and FSM live in the top module.

## Test plan
- Write only: init_done=1, wrf_usedw=256, rdf_usedw=512, ack pulse 256 cycles.
  - wr_req high 1 cycle after idle; sys_addr=0.
  - After ack falls, level=256 and sdram_empty=0.
  - Next request address is 256.
- Alternation: level=1024, wrf_usedw=300, rdf_usedw=0.
  - Requests go W, R, W, R.
  - Read addresses are 0, 256; write addresses continue from 1024.
- Wrap: force wr_ptr=2^22−256, run one write burst.
  - wr_ptr=0 and sys_addr=0 on the next write.
- Full boundary: level=2^22−256, wrf_usedw=512.
  - After one burst, sdram_full=1 and no further wr_req.
  - A read completion clears full.
- Flush mid-burst: assert flush during S_WBURST.
  - The burst completes normally on the ack interface.
  - Then pointers=0, level=0, empty=1.
- Reset mid-request: drop rst_n while rd_req=1.
  - rd_req=0 asynchronously, level=0, state S_IDLE.
  - No request is issued until init_done is high again.

Source files
------------

// File: rtl/sdram_sched_pkg.sv
// Shared definitions for the SDRAM request scheduler: parameter defaults,
// FIFO fill-level width and the scheduler FSM state encoding.
package sdram_sched_pkg;

    localparam int BURST_LEN_DEF = 256;
    localparam int ADDR_W_DEF    = 22;
    localparam int RDF_DEPTH_DEF = 512;
    localparam int USEDW_W       = 10;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WREQ   = 3'd1,
        S_WBURST = 3'd2,
        S_RREQ   = 3'd3,
        S_RBURST = 3'd4,
        S_GAP    = 3'd5
    } state_e;

endpackage

// File: rtl/sdram_burst_ptr.sv
// Wrapping SDRAM word pointer that advances by one burst per completion.
// The pointer rolls over modulo 2^ADDR_W; bursts never straddle the wrap.
module sdram_burst_ptr
    import sdram_sched_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int STEP   = BURST_LEN_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    input  logic              clr,
    output logic [ADDR_W-1:0] ptr
);

    logic [ADDR_W-1:0] ptr_d;
    logic [ADDR_W-1:0] ptr_q;

    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (inc) begin
            ptr_d = ptr_q + ADDR_W'(STEP);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/sdram_req_sched.sv
// Issues one full-burst write or read request at a time from FIFO fill levels,
// tracking SDRAM write/read pointers and occupancy so the SDRAM acts as one FIFO.
module sdram_req_sched
    import sdram_sched_pkg::*;
#(
    parameter int BURST_LEN = BURST_LEN_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int RDF_DEPTH = RDF_DEPTH_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sdram_init_done,
    input  logic               flush,
    input  logic [9:0]         wrf_usedw,
    input  logic [9:0]         rdf_usedw,
    output logic               sdram_wr_req,
    output logic               sdram_rd_req,
    input  logic               sdram_wr_ack,
    input  logic               sdram_rd_ack,
    output logic [9:0]         sdwr_byte,
    output logic [9:0]         sdrd_byte,
    output logic [ADDR_W-1:0]  sys_addr,
    output logic [ADDR_W:0]    sdram_level,
    output logic               sdram_full,
    output logic               sdram_empty
);

    localparam int                 LVL_W    = ADDR_W + 1;
    localparam int                 DEPTH    = 2 ** ADDR_W;
    localparam logic [LVL_W-1:0]   LVL_STEP = LVL_W'(BURST_LEN);
    localparam logic [LVL_W-1:0]   FULL_THR = LVL_W'(DEPTH - BURST_LEN);
    localparam logic [USEDW_W-1:0] WR_MIN   = USEDW_W'(BURST_LEN);
    localparam logic [USEDW_W-1:0] RD_MAX   = USEDW_W'(RDF_DEPTH - BURST_LEN);

    state_e             state_q, state_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               last_wr_q, last_wr_d;
    logic               flush_pend_q, flush_pend_d;
    logic               wr_req_q, wr_req_d;
    logic               rd_req_q, rd_req_d;
    logic [ADDR_W-1:0]  sys_addr_q, sys_addr_d;
    logic [ADDR_W-1:0]  wr_ptr, rd_ptr;
    logic               wr_ok, rd_ok, flush_any, busy;
    logic               wr_done, rd_done, clr;

    assign sdram_full  = (level_q > FULL_THR);
    assign sdram_empty = (level_q < LVL_STEP);
    assign wr_ok       = sdram_init_done && (wrf_usedw >= WR_MIN) && !sdram_full;
    assign rd_ok       = sdram_init_done && !sdram_empty && (rdf_usedw <= RD_MAX);
    assign flush_any   = flush || flush_pend_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!flush) begin
                    // On a tie, alternate away from whichever direction ran last.
                    if (wr_ok && (!rd_ok || !last_wr_q)) begin
                        state_d = S_WREQ;
                    end else if (rd_ok) begin
                        state_d = S_RREQ;
                    end
                end
            end
            S_WREQ:   if (sdram_wr_ack)  state_d = S_WBURST;
            S_WBURST: if (!sdram_wr_ack) state_d = S_GAP;
            S_RREQ:   if (sdram_rd_ack)  state_d = S_RBURST;
            S_RBURST: if (!sdram_rd_ack) state_d = S_GAP;
            S_GAP:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_q == S_WREQ) || (state_q == S_WBURST) ||
                  (state_q == S_RREQ) || (state_q == S_RBURST);
        // A flush seen during a burst discards that burst's bookkeeping update.
        wr_done = (state_q == S_WBURST) && !sdram_wr_ack && !flush_any;
        rd_done = (state_q == S_RBURST) && !sdram_rd_ack && !flush_any;
        clr     = ((state_q == S_IDLE) || (state_q == S_GAP)) && flush_any;

        flush_pend_d = busy && flush_any;
        level_d      = level_q;
        last_wr_d    = last_wr_q;
        if (clr) begin
            level_d   = '0;
            last_wr_d = 1'b0;
        end else if (wr_done) begin
            level_d   = level_q + LVL_STEP;
            last_wr_d = 1'b1;
        end else if (rd_done) begin
            level_d   = level_q - LVL_STEP;
            last_wr_d = 1'b0;
        end

        wr_req_d   = (state_d == S_WREQ);
        rd_req_d   = (state_d == S_RREQ);
        sys_addr_d = ((state_d == S_RREQ) || (state_d == S_RBURST)) ? rd_ptr : wr_ptr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q      <= '0;
            last_wr_q    <= 1'b0;
            flush_pend_q <= 1'b0;
            wr_req_q     <= 1'b0;
            rd_req_q     <= 1'b0;
            sys_addr_q   <= '0;
        end else begin
            level_q      <= level_d;
            last_wr_q    <= last_wr_d;
            flush_pend_q <= flush_pend_d;
            wr_req_q     <= wr_req_d;
            rd_req_q     <= rd_req_d;
            sys_addr_q   <= sys_addr_d;
        end
    end

    sdram_burst_ptr #(.ADDR_W(ADDR_W), .STEP(BURST_LEN)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (wr_done),
        .clr   (clr),
        .ptr   (wr_ptr)
    );

    sdram_burst_ptr #(.ADDR_W(ADDR_W), .STEP(BURST_LEN)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (rd_done),
        .clr   (clr),
        .ptr   (rd_ptr)
    );

    assign sdram_wr_req = wr_req_q;
    assign sdram_rd_req = rd_req_q;
    assign sys_addr     = sys_addr_q;
    assign sdram_level  = level_q;
    assign sdwr_byte    = 10'(BURST_LEN);
    assign sdrd_byte    = 10'(BURST_LEN);

endmodule
